// File: rtl/axis_chk_syn.sv
// AXI-Stream sink that checks an incrementing-word stream frame by frame.
// Reports frame count, error count and pass/fail, with LFSR-throttled tready.
module axis_chk_syn #(
   parameter int DATA_WIDTH = 32,
   parameter int FRAME_LEN  = 16,
   parameter int NUM_FRAMES = 4,
   parameter int EXP_DEST   = 0,
   parameter int THROTTLE   = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [DATA_WIDTH-1:0]   S_AXIS_tdata,
   input  logic [3:0]              S_AXIS_tdest,
   input  logic [DATA_WIDTH/8-1:0] S_AXIS_tkeep,
   input  logic                    S_AXIS_tlast,
   input  logic                    S_AXIS_tvalid,
   output logic                    S_AXIS_tready,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic [15:0]             frame_cnt,
   output logic [15:0]             err_cnt
);

   if (DATA_WIDTH % 8 != 0 || FRAME_LEN < 1 || NUM_FRAMES < 1) begin : g_param_chk
      $fatal(1, "axis_chk_syn: illegal parameters");
   end

   localparam int                    KW          = DATA_WIDTH / 8;
   localparam logic [31:0]           LAST_IDX    = 32'(FRAME_LEN - 1);
   localparam logic [15:0]           FINAL_FRAME = 16'(NUM_FRAMES - 1);
   localparam logic [DATA_WIDTH-1:0] ONE_W       = 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                r_state;
   logic                  r_tready, r_busy, r_done, r_pass;
   logic [15:0]           r_frame_cnt, r_err_cnt;
   logic [31:0]           r_idx;
   logic [DATA_WIDTH-1:0] r_word;
   logic [15:0]           r_lfsr;

   logic                  w_acc, w_at_last, w_mis, w_eof, w_final;
   logic [15:0]           w_err_nxt, w_lfsr_nxt;

   assign w_acc     = (r_state == S_RUN) && r_tready && S_AXIS_tvalid;
   assign w_at_last = (r_idx == LAST_IDX);
   // Any number of mismatching fields on one beat is a single error.
   assign w_mis     = (S_AXIS_tdata != r_word) || (S_AXIS_tkeep != {KW{1'b1}}) ||
                      (S_AXIS_tdest != 4'(EXP_DEST)) || (S_AXIS_tlast != w_at_last);
   // Frame closes on tlast (resync) or on reaching FRAME_LEN beats.
   assign w_eof     = S_AXIS_tlast || w_at_last;
   assign w_final   = w_acc && w_eof && (r_frame_cnt == FINAL_FRAME);
   assign w_err_nxt = (w_acc && w_mis && r_err_cnt != 16'hFFFF) ? r_err_cnt + 16'd1 : r_err_cnt;
   assign w_lfsr_nxt = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_tready    <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_frame_cnt <= '0;
         r_err_cnt   <= '0;
         r_idx       <= '0;
         r_word      <= '0;
         r_lfsr      <= 16'hACE1;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: if (start) begin
               r_state     <= S_RUN;
               r_busy      <= 1'b1;
               r_tready    <= (THROTTLE != 0) ? r_lfsr[0] : 1'b1;
               r_idx       <= '0;
               r_word      <= '0;
               r_frame_cnt <= '0;
               r_err_cnt   <= '0;
               r_pass      <= 1'b0;
            end
            S_RUN: begin
               r_lfsr    <= w_lfsr_nxt;
               r_tready  <= (THROTTLE != 0) ? w_lfsr_nxt[0] : 1'b1;
               r_err_cnt <= w_err_nxt;
               if (w_acc) begin
                  r_word <= r_word + ONE_W;
                  if (w_eof) begin
                     r_idx       <= '0;
                     r_frame_cnt <= r_frame_cnt + 16'd1;
                  end else begin
                     r_idx <= r_idx + 32'd1;
                  end
               end
               if (w_final) begin
                  r_state  <= S_DONE;
                  r_busy   <= 1'b0;
                  r_tready <= 1'b0;
                  r_done   <= 1'b1;
                  r_pass   <= (w_err_nxt == 16'd0);
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign S_AXIS_tready = r_tready;
   assign busy          = r_busy;
   assign done          = r_done;
   assign pass          = r_pass;
   assign frame_cnt     = r_frame_cnt;
   assign err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_axis_chk_syn.sv
// Directed bench for axis_chk_syn: one unthrottled and one LFSR-throttled instance.
module tb_axis_chk_syn;
   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [1:0]       start = '0;
   logic [1:0]       tvalid = '0;
   logic [31:0]      tdata = '0;
   logic [3:0]       tdest = '0;
   logic [3:0]       tkeep = '0;
   logic             tlast = 1'b0;
   logic [1:0]       tready, busy, done, pass;
   logic [1:0][15:0] fcnt, ecnt;

   int n_chk = 0, n_fail = 0;
   int acc1 = 0, rdy_low1 = 0;

   always #5 clk = ~clk;

   axis_chk_syn #(.DATA_WIDTH(32), .FRAME_LEN(16), .NUM_FRAMES(4), .EXP_DEST(0), .THROTTLE(0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start[0]),
      .S_AXIS_tdata(tdata), .S_AXIS_tdest(tdest), .S_AXIS_tkeep(tkeep), .S_AXIS_tlast(tlast),
      .S_AXIS_tvalid(tvalid[0]), .S_AXIS_tready(tready[0]),
      .busy(busy[0]), .done(done[0]), .pass(pass[0]), .frame_cnt(fcnt[0]), .err_cnt(ecnt[0]));

   axis_chk_syn #(.DATA_WIDTH(32), .FRAME_LEN(16), .NUM_FRAMES(4), .EXP_DEST(0), .THROTTLE(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start[1]),
      .S_AXIS_tdata(tdata), .S_AXIS_tdest(tdest), .S_AXIS_tkeep(tkeep), .S_AXIS_tlast(tlast),
      .S_AXIS_tvalid(tvalid[1]), .S_AXIS_tready(tready[1]),
      .busy(busy[1]), .done(done[1]), .pass(pass[1]), .frame_cnt(fcnt[1]), .err_cnt(ecnt[1]));

   always @(posedge clk) begin
      if (busy[1] && !tready[1]) rdy_low1 = rdy_low1 + 1;
      if (tvalid[1] && tready[1]) acc1 = acc1 + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one beat at a negedge and hold it until the DUT takes it.
   task automatic beat(input int s, input logic [31:0] d, input logic [3:0] k,
                       input logic [3:0] de, input logic l);
      int n;
      tdata = d; tkeep = k; tdest = de; tlast = l; tvalid[s] = 1'b1;
      n = 0;
      while (tready[s] !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("beat_timeout", 32'(n), 32'd0);
      @(negedge clk);
      tvalid[s] = 1'b0;
   endtask

   task automatic pulse_start(input int s);
      start[s] = 1'b1;
      @(negedge clk);
      start[s] = 1'b0;
   endtask

   // kind 1: corrupt data on beat 5; kind 3: bad keep and dest on beat 5
   task automatic run_std(input int s, input int kind, input int nbeats);
      logic [31:0] d;
      logic [3:0]  k, de;
      for (int i = 0; i < nbeats; i++) begin
         d = 32'(i); k = 4'hF; de = 4'd0;
         if (kind == 1 && i == 5) d = 32'hDEADBEEF;
         if (kind == 3 && i == 5) begin k = 4'h7; de = 4'd3; end
         beat(s, d, k, de, (i % 16) == 15);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_tready", 32'(tready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done_pass", {30'd0, done | pass}, 32'd0);
      chk("rst_cnts", {fcnt[0] | fcnt[1], ecnt[0] | ecnt[1]}, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // valid while idle is ignored
      tvalid[0] = 1'b1; tdata = 32'h1234; tlast = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_tready", 32'(tready[0]), 32'd0);
      chk("idle_err", 32'(ecnt[0]), 32'd0);
      tvalid[0] = 1'b0;

      // clean run
      pulse_start(0);
      chk("run_busy", 32'(busy[0]), 32'd1);
      chk("run_tready", 32'(tready[0]), 32'd1);
      run_std(0, 0, 64);
      chk("clean_done", 32'(done[0]), 32'd1);
      chk("clean_pass", 32'(pass[0]), 32'd1);
      chk("clean_fcnt", 32'(fcnt[0]), 32'd4);
      chk("clean_ecnt", 32'(ecnt[0]), 32'd0);
      chk("clean_tready_done", 32'(tready[0]), 32'd0);
      @(negedge clk);
      chk("clean_done_1cyc", 32'(done[0]), 32'd0);
      chk("clean_busy_off", 32'(busy[0]), 32'd0);
      chk("clean_pass_hold", 32'(pass[0]), 32'd1);

      // corrupted data
      pulse_start(0);
      chk("start_clr_pass", 32'(pass[0]), 32'd0);
      chk("start_clr_fcnt", 32'(fcnt[0]), 32'd0);
      run_std(0, 1, 64);
      chk("data_done", 32'(done[0]), 32'd1);
      chk("data_pass", 32'(pass[0]), 32'd0);
      chk("data_ecnt", 32'(ecnt[0]), 32'd1);
      chk("data_fcnt", 32'(fcnt[0]), 32'd4);
      @(negedge clk);

      // keep and dest both wrong on one beat
      pulse_start(0);
      run_std(0, 3, 64);
      chk("kd_ecnt", 32'(ecnt[0]), 32'd1);
      chk("kd_pass", 32'(pass[0]), 32'd0);
      @(negedge clk);

      // early tlast on beat 9 resyncs; 10 + 3*16 = 58 beats
      pulse_start(0);
      for (int i = 0; i < 58; i++) begin
         beat(0, 32'(i), 4'hF, 4'd0, (i == 9) || (i > 9 && ((i - 10) % 16) == 15));
         if (i == 8) chk("early_fcnt_pre", 32'(fcnt[0]), 32'd0);
         if (i == 9) chk("early_fcnt_post", 32'(fcnt[0]), 32'd1);
         if (i == 9) chk("early_ecnt", 32'(ecnt[0]), 32'd1);
      end
      chk("early_done", 32'(done[0]), 32'd1);
      chk("early_fcnt_end", 32'(fcnt[0]), 32'd4);
      chk("early_ecnt_end", 32'(ecnt[0]), 32'd1);
      @(negedge clk);

      // reset in the middle of frame 1
      pulse_start(0);
      run_std(0, 0, 20);
      rst = 1'b0;
      #1;
      chk("mrst_tready", 32'(tready[0]), 32'd0);
      chk("mrst_busy", 32'(busy[0]), 32'd0);
      chk("mrst_cnts", {fcnt[0], ecnt[0]}, 32'd0);
      chk("mrst_pass", 32'(pass[0]), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      pulse_start(0);
      run_std(0, 0, 64);
      chk("mrst_run_done", 32'(done[0]), 32'd1);
      chk("mrst_run_pass", 32'(pass[0]), 32'd1);
      chk("mrst_run_fcnt", 32'(fcnt[0]), 32'd4);
      @(negedge clk);

      // throttled instance: LFSR from 16'hACE1 gives tready 1,0,0,0
      pulse_start(1);
      chk("thr_rdy0", 32'(tready[1]), 32'd1);
      @(negedge clk);
      chk("thr_rdy1", 32'(tready[1]), 32'd0);
      @(negedge clk);
      chk("thr_rdy2", 32'(tready[1]), 32'd0);
      @(negedge clk);
      chk("thr_rdy3", 32'(tready[1]), 32'd0);
      run_std(1, 0, 64);
      chk("thr_done", 32'(done[1]), 32'd1);
      chk("thr_pass", 32'(pass[1]), 32'd1);
      chk("thr_fcnt", 32'(fcnt[1]), 32'd4);
      chk("thr_ecnt", 32'(ecnt[1]), 32'd0);
      chk("thr_acc", 32'(acc1), 32'd64);
      chk("thr_stalled", 32'(rdy_low1 > 3), 32'd1);
      @(negedge clk);
      chk("thr_done_1cyc", 32'(done[1]), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
